sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_rr_arbiter.sv | 26 ++
 rtl/sdram_port_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StAdvance
  } arb_state_e;

  localparam int unsigned DefNumRd   = 2;
  localparam int unsigned DefNumWr   = 2;
  localparam int unsigned DefAsize   = 23;
  localparam int unsigned DefLenW    = 9;
  localparam int unsigned DefUsedwW  = 16;

  // Round-robin pointer value after reset: port 0 searched first.
  localparam int unsigned RrPtrReset = 0;

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
module sdram_rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW-1:0] idx;

  // Walk from the farthest offset down so the nearest requester is the last writer.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_i) + i) % int'(N));
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates burst requests from multiple read/write FIFO ports onto one SDRAM controller core.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_RD     = DefNumRd,
  parameter int unsigned NUM_WR     = DefNumWr,
  parameter int unsigned ASIZE      = DefAsize,
  parameter int unsigned LEN_W      = DefLenW,
  parameter int unsigned USEDW_W    = DefUsedwW,
  parameter int unsigned READ_FIRST = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NUM_RD*ASIZE-1:0]     RD_ADDR,
  input  logic [NUM_RD*ASIZE-1:0]     RD_MAX_ADDR,
  input  logic [NUM_RD*LEN_W-1:0]     RD_LENGTH,
  input  logic [NUM_RD-1:0]           RD_LOAD,
  input  logic [NUM_RD*USEDW_W-1:0]   RD_WUSEDW,
  input  logic [NUM_WR*ASIZE-1:0]     WR_ADDR,
  input  logic [NUM_WR*ASIZE-1:0]     WR_MAX_ADDR,
  input  logic [NUM_WR*LEN_W-1:0]     WR_LENGTH,
  input  logic [NUM_WR-1:0]           WR_LOAD,
  input  logic [NUM_WR*USEDW_W-1:0]   WR_RUSEDW,
  output logic                        REQ,
  output logic                        REQ_WRITE,
  output logic [ASIZE-1:0]            REQ_ADDR,
  output logic [LEN_W-1:0]            REQ_LENGTH,
  input  logic                        REQ_ACK,
  input  logic                        REQ_DONE,
  output logic [NUM_RD-1:0]           RD_MASK,
  output logic [NUM_WR-1:0]           WR_MASK,
  output logic                        BUSY
);

  localparam int unsigned NTOT = NUM_RD + NUM_WR;
  localparam int unsigned RPW  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned WPW  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int unsigned NPW  = $clog2(NTOT);
  localparam int unsigned IW   = (RPW > WPW) ? RPW : WPW;

  arb_state_e state_q, state_d;
  logic req_q, req_d, req_write_q, req_write_d, busy_q, busy_d;
  logic load_seen_q, load_seen_d;
  logic [ASIZE-1:0]  req_addr_q, req_addr_d;
  logic [LEN_W-1:0]  req_length_q, req_length_d;
  logic [NUM_RD-1:0] rd_mask_q, rd_mask_d;
  logic [NUM_WR-1:0] wr_mask_q, wr_mask_d;
  logic [RPW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WPW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [NPW-1:0]    ring_ptr_q, ring_ptr_d;
  logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [ASIZE-1:0]  rd_addr_q [NUM_RD];
  logic [ASIZE-1:0]  rd_addr_d [NUM_RD];
  logic [ASIZE-1:0]  wr_addr_q [NUM_WR];
  logic [ASIZE-1:0]  wr_addr_d [NUM_WR];

  logic [ASIZE-1:0]   rd_start [NUM_RD];
  logic [ASIZE-1:0]   rd_max   [NUM_RD];
  logic [LEN_W-1:0]   rd_len   [NUM_RD];
  logic [USEDW_W-1:0] rd_used  [NUM_RD];
  logic [ASIZE-1:0]   wr_start [NUM_WR];
  logic [ASIZE-1:0]   wr_max   [NUM_WR];
  logic [LEN_W-1:0]   wr_len   [NUM_WR];
  logic [USEDW_W-1:0] wr_used  [NUM_WR];

  logic [NUM_RD-1:0] rd_elig, rd_gnt, rd_sel;
  logic [NUM_WR-1:0] wr_elig, wr_gnt, wr_sel;
  logic [NTOT-1:0]   ring_req, ring_gnt;
  logic [RPW-1:0]    rd_idx;
  logic [WPW-1:0]    wr_idx;
  logic              gnt_load;

  function automatic logic [ASIZE-1:0] next_addr(input logic [ASIZE-1:0] addr,
                                                 input logic [ASIZE-1:0] max_addr,
                                                 input logic [ASIZE-1:0] start,
                                                 input logic [LEN_W-1:0] len);
    logic [ASIZE:0] len_x, limit;
    len_x = (ASIZE+1)'(len);
    limit = {1'b0, max_addr} - len_x;
    if ({1'b0, addr} < limit) next_addr = addr + ASIZE'(len);
    else                      next_addr = start;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_start[i] = RD_ADDR[i*ASIZE +: ASIZE];
      rd_max[i]   = RD_MAX_ADDR[i*ASIZE +: ASIZE];
      rd_len[i]   = RD_LENGTH[i*LEN_W +: LEN_W];
      rd_used[i]  = RD_WUSEDW[i*USEDW_W +: USEDW_W];
      rd_elig[i]  = (rd_len[i] != '0) && (32'(rd_used[i]) < 32'(rd_len[i])) && !RD_LOAD[i];
    end
    for (int j = 0; j < NUM_WR; j++) begin
      wr_start[j] = WR_ADDR[j*ASIZE +: ASIZE];
      wr_max[j]   = WR_MAX_ADDR[j*ASIZE +: ASIZE];
      wr_len[j]   = WR_LENGTH[j*LEN_W +: LEN_W];
      wr_used[j]  = WR_RUSEDW[j*USEDW_W +: USEDW_W];
      wr_elig[j]  = (wr_len[j] != '0) && (32'(wr_used[j]) >= 32'(wr_len[j])) && !WR_LOAD[j];
    end
  end

  assign ring_req = {wr_elig, rd_elig};

  sdram_rr_arbiter #(.N(NUM_RD)) u_rd_arb (.req_i(rd_elig),  .ptr_i(rd_ptr_q),   .gnt_o(rd_gnt));
  sdram_rr_arbiter #(.N(NUM_WR)) u_wr_arb (.req_i(wr_elig),  .ptr_i(wr_ptr_q),   .gnt_o(wr_gnt));
  sdram_rr_arbiter #(.N(NTOT))   u_ring   (.req_i(ring_req), .ptr_i(ring_ptr_q), .gnt_o(ring_gnt));

  always_comb begin
    rd_sel = '0;
    wr_sel = '0;
    if (READ_FIRST != 0) begin
      if (|rd_elig) rd_sel = rd_gnt;
      else          wr_sel = wr_gnt;
    end else begin
      rd_sel = ring_gnt[NUM_RD-1:0];
      wr_sel = ring_gnt[NTOT-1:NUM_RD];
    end
    rd_idx = '0;
    for (int i = 0; i < NUM_RD; i++) if (rd_sel[i]) rd_idx = RPW'(i);
    wr_idx = '0;
    for (int j = 0; j < NUM_WR; j++) if (wr_sel[j]) wr_idx = WPW'(j);
    gnt_load = 1'b0;
    for (int i = 0; i < NUM_RD; i++)
      if (!req_write_q && gnt_idx_q == IW'(i) && RD_LOAD[i]) gnt_load = 1'b1;
    for (int j = 0; j < NUM_WR; j++)
      if (req_write_q && gnt_idx_q == IW'(j) && WR_LOAD[j]) gnt_load = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_length_d = req_length_q;
    rd_mask_d    = rd_mask_q;
    wr_mask_d    = wr_mask_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    ring_ptr_d   = ring_ptr_q;
    gnt_idx_d    = gnt_idx_q;
    load_seen_d  = load_seen_q;

    unique case (state_q)
      StIdle: begin
        load_seen_d = 1'b0;
        if (|rd_sel) begin
          state_d      = StIssue;
          req_d        = 1'b1;
          req_write_d  = 1'b0;
          req_addr_d   = rd_addr_q[rd_idx];
          req_length_d = rd_len[rd_idx];
          rd_mask_d    = rd_sel;
          wr_mask_d    = '0;
          gnt_idx_d    = IW'(rd_idx);
          rd_ptr_d     = RPW'((int'(rd_idx) + 1) % int'(NUM_RD));
          ring_ptr_d   = NPW'((int'(rd_idx) + 1) % int'(NTOT));
        end else if (|wr_sel) begin
          state_d      = StIssue;
          req_d        = 1'b1;
          req_write_d  = 1'b1;
          req_addr_d   = wr_addr_q[wr_idx];
          req_length_d = wr_len[wr_idx];
          rd_mask_d    = '0;
          wr_mask_d    = wr_sel;
          gnt_idx_d    = IW'(wr_idx);
          wr_ptr_d     = WPW'((int'(wr_idx) + 1) % int'(NUM_WR));
          ring_ptr_d   = NPW'((int'(NUM_RD) + int'(wr_idx) + 1) % int'(NTOT));
        end
      end
      StIssue: begin
        load_seen_d = load_seen_q | gnt_load;
        if (REQ_ACK) begin
          req_d   = 1'b0;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        load_seen_d = load_seen_q | gnt_load;
        if (REQ_DONE) begin
          state_d   = StAdvance;
          rd_mask_d = '0;
          wr_mask_d = '0;
        end
      end
      StAdvance: begin
        load_seen_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A reload seen any time during the burst suppresses the post-burst advance.
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr_d[i] = rd_addr_q[i];
      if (RD_LOAD[i]) begin
        rd_addr_d[i] = rd_start[i];
      end else if (state_q == StAdvance && !req_write_q && gnt_idx_q == IW'(i)) begin
        rd_addr_d[i] = load_seen_q ? rd_start[i]
                                   : next_addr(rd_addr_q[i], rd_max[i], rd_start[i], rd_len[i]);
      end
    end
    for (int j = 0; j < NUM_WR; j++) begin
      wr_addr_d[j] = wr_addr_q[j];
      if (WR_LOAD[j]) begin
        wr_addr_d[j] = wr_start[j];
      end else if (state_q == StAdvance && req_write_q && gnt_idx_q == IW'(j)) begin
        wr_addr_d[j] = load_seen_q ? wr_start[j]
                                   : next_addr(wr_addr_q[j], wr_max[j], wr_start[j], wr_len[j]);
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_length_q <= '0;
      rd_mask_q    <= '0;
      wr_mask_q    <= '0;
      busy_q       <= 1'b0;
      load_seen_q  <= 1'b0;
      gnt_idx_q    <= '0;
      rd_ptr_q     <= RPW'(RrPtrReset);
      wr_ptr_q     <= WPW'(RrPtrReset);
      ring_ptr_q   <= NPW'(RrPtrReset);
      for (int i = 0; i < NUM_RD; i++) rd_addr_q[i] <= rd_start[i];
      for (int j = 0; j < NUM_WR; j++) wr_addr_q[j] <= wr_start[j];
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_length_q <= req_length_d;
      rd_mask_q    <= rd_mask_d;
      wr_mask_q    <= wr_mask_d;
      busy_q       <= busy_d;
      load_seen_q  <= load_seen_d;
      gnt_idx_q    <= gnt_idx_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      ring_ptr_q   <= ring_ptr_d;
      for (int i = 0; i < NUM_RD; i++) rd_addr_q[i] <= rd_addr_d[i];
      for (int j = 0; j < NUM_WR; j++) wr_addr_q[j] <= wr_addr_d[j];
    end
  end

  assign REQ        = req_q;
  assign REQ_WRITE  = req_write_q;
  assign REQ_ADDR   = req_addr_q;
  assign REQ_LENGTH = req_length_q;
  assign RD_MASK    = rd_mask_q;
  assign WR_MASK    = wr_mask_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: eligibility table plus multi-burst sequences.
module tb_sdram_port_arbiter;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int A  = 23;
  localparam int L  = 9;
  localparam int U  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR*A-1:0] rd_addr, rd_max;
  logic [NR*L-1:0] rd_length;
  logic [NR-1:0]   rd_load;
  logic [NR*U-1:0] rd_wusedw;
  logic [NW*A-1:0] wr_addr, wr_max;
  logic [NW*L-1:0] wr_length;
  logic [NW-1:0]   wr_load;
  logic [NW*U-1:0] wr_rusedw;
  logic          req, req_write, req_ack, req_done, busy;
  logic [A-1:0]  req_addr;
  logic [L-1:0]  req_length;
  logic [NR-1:0] rd_mask;
  logic [NW-1:0] wr_mask;

  sdram_port_arbiter dut (
    .CLK(clk), .RESET(reset),
    .RD_ADDR(rd_addr), .RD_MAX_ADDR(rd_max), .RD_LENGTH(rd_length), .RD_LOAD(rd_load),
    .RD_WUSEDW(rd_wusedw),
    .WR_ADDR(wr_addr), .WR_MAX_ADDR(wr_max), .WR_LENGTH(wr_length), .WR_LOAD(wr_load),
    .WR_RUSEDW(wr_rusedw),
    .REQ(req), .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_LENGTH(req_length),
    .REQ_ACK(req_ack), .REQ_DONE(req_done),
    .RD_MASK(rd_mask), .WR_MASK(wr_mask), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0] rl0, rl1;
    logic [U-1:0] ru0, ru1;
    logic [L-1:0] wl0, wl1;
    logic [U-1:0] wu0, wu1;
    logic [1:0]   rld, wld;
    logic         exp_req;
    logic [1:0]   exp_rm, exp_wm;
    logic         exp_wr;
    logic [A-1:0] exp_addr;
    logic [L-1:0] exp_len;
  } vec_t;

  vec_t  vecs [12];
  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h expected=%0h", tag, name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (req !== 1'b1 && n < 8) begin
      tick;
      n++;
    end
  endtask

  // Waits for a grant and checks latency (1 cycle from IDLE) and every request output.
  task automatic expect_grant(input logic [1:0] rm, input logic [1:0] wm, input logic wr,
                              input logic [A-1:0] addr, input logic [L-1:0] len);
    int n;
    wait_req(n);
    chk("latency", n, 1);
    chk("rd_mask", 32'(rd_mask), 32'(rm));
    chk("wr_mask", 32'(wr_mask), 32'(wm));
    chk("req_write", 32'(req_write), 32'(wr));
    chk("req_addr", 32'(req_addr), 32'(addr));
    chk("req_length", 32'(req_length), 32'(len));
    chk("busy", 32'(busy), 1);
  endtask

  // Holds ISSUE one idle cycle, acks, optionally pulses WR_LOAD[0] in WAIT_DONE, then completes.
  task automatic finish_burst(input bit pulse_wload0);
    tick;
    chk("req_hold", 32'(req), 1);
    req_ack = 1'b1;
    tick;
    req_ack = 1'b0;
    chk("req_drop", 32'(req), 0);
    chk("mask_wait", 32'({rd_mask, wr_mask}) != 0, 1);
    if (pulse_wload0) begin
      wr_load = 2'b01;
      tick;
      wr_load = 2'b00;
      chk("mask_load", 32'(wr_mask), 32'h1);
    end else begin
      tick;
    end
    req_done = 1'b1;
    tick;
    req_done = 1'b0;
    chk("mask_clr", 32'({rd_mask, wr_mask}), 0);
    tick;
    chk("adv_req", 32'(req), 0);
  endtask

  task automatic apply_vec(input vec_t v);
    rd_length = {v.rl1, v.rl0};
    rd_wusedw = {v.ru1, v.ru0};
    wr_length = {v.wl1, v.wl0};
    wr_rusedw = {v.wu1, v.wu0};
    rd_load   = v.rld;
    wr_load   = v.wld;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    //          rl0   rl1   ru0   ru1   wl0   wl1   wu0   wu1  rld  wld req rm wm wr addr len
    vecs[0]  = '{256, 256,    0,    0,    0,    0,    0,    0, 0, 0, 1, 1, 0, 0, 'h1000, 256};
    vecs[1]  = '{  0, 256,    0,    0,    0,    0,    0,    0, 0, 0, 1, 2, 0, 0, 'h2000, 256};
    vecs[2]  = '{256, 256,  256,  255,    0,    0,    0,    0, 0, 0, 1, 2, 0, 0, 'h2000, 256};
    vecs[3]  = '{  0,   0,    0,    0,  256,  256,  300,  256, 0, 0, 1, 0, 1, 1, 'h3000, 256};
    vecs[4]  = '{  0,   0,    0,    0,  256,  256,  255,  256, 0, 0, 1, 0, 2, 1, 'h4000, 256};
    vecs[5]  = '{256,   0,    0,    0,  256,    0,  300,    0, 0, 0, 1, 1, 0, 0, 'h1000, 256};
    vecs[6]  = '{256, 256,    0,    0,    0,    0,    0,    0, 1, 0, 1, 2, 0, 0, 'h2000, 256};
    vecs[7]  = '{  0,   0,    0,    0,    0,    0,  500,  500, 0, 0, 0, 0, 0, 0, 'h0,      0};
    vecs[8]  = '{  0,   0,    0,    0,  256,  256,  300,  300, 0, 1, 1, 0, 2, 1, 'h4000, 256};
    vecs[9]  = '{100,   0,   99,    0,    0,    0,    0,    0, 0, 0, 1, 1, 0, 0, 'h1000, 100};
    vecs[10] = '{100,   0,  100,    0,    0,    0,    0,    0, 0, 0, 0, 0, 0, 0, 'h0,      0};
    vecs[11] = '{  0,   0,    0,    0,  256,    0,  255,    0, 0, 0, 0, 0, 0, 0, 'h0,      0};

    rd_addr = {23'h2000, 23'h1000};
    wr_addr = {23'h4000, 23'h3000};
    rd_max  = {23'h100000, 23'h100000};
    wr_max  = {23'h100000, 23'h100000};
    req_ack = 1'b0;
    req_done = 1'b0;
    apply_vec(vecs[7]);

    tag = "reset";
    do_reset;
    chk("req", 32'(req), 0);
    chk("req_write", 32'(req_write), 0);
    chk("req_addr", 32'(req_addr), 0);
    chk("req_length", 32'(req_length), 0);
    chk("masks", 32'({rd_mask, wr_mask}), 0);
    chk("busy", 32'(busy), 0);

    for (int k = 0; k < 12; k++) begin
      tag = $sformatf("vec%0d", k);
      apply_vec(vecs[k]);
      do_reset;
      if (vecs[k].exp_req) begin
        expect_grant(vecs[k].exp_rm, vecs[k].exp_wm, vecs[k].exp_wr, vecs[k].exp_addr,
                     vecs[k].exp_len);
        rd_load = '0;
        wr_load = '0;
        finish_burst(1'b0);
      end else begin
        for (int c = 0; c < 6; c++) tick;
        chk("no_req", 32'(req), 0);
        chk("no_busy", 32'(busy), 0);
      end
    end

    // Round-robin between two always-eligible read ports, addresses advancing per port.
    tag = "rr";
    apply_vec(vecs[0]);
    do_reset;
    expect_grant(2'b01, 2'b00, 1'b0, 23'h1000, 256); finish_burst(1'b0);
    expect_grant(2'b10, 2'b00, 1'b0, 23'h2000, 256); finish_burst(1'b0);
    expect_grant(2'b01, 2'b00, 1'b0, 23'h1100, 256); finish_burst(1'b0);
    expect_grant(2'b10, 2'b00, 1'b0, 23'h2100, 256); finish_burst(1'b0);

    // Wrap: next = addr+len while addr < max-len (0<768, 256<768, 512<768), else start.
    tag = "wrap";
    rd_addr = {23'h2000, 23'h0};
    rd_max  = {23'h100000, 23'd1024};
    rd_length = {9'd0, 9'd256};
    rd_wusedw = '0;
    do_reset;
    expect_grant(2'b01, 2'b00, 1'b0, 23'd0,   256); finish_burst(1'b0);
    expect_grant(2'b01, 2'b00, 1'b0, 23'd256, 256); finish_burst(1'b0);
    expect_grant(2'b01, 2'b00, 1'b0, 23'd512, 256); finish_burst(1'b0);
    expect_grant(2'b01, 2'b00, 1'b0, 23'd768, 256); finish_burst(1'b0);
    expect_grant(2'b01, 2'b00, 1'b0, 23'd0,   256); finish_burst(1'b0);
    rd_addr = {23'h2000, 23'h1000};
    rd_max  = {23'h100000, 23'h100000};

    // Read outranks an eligible write; write goes once the read FIFO is full.
    tag = "rdfirst";
    apply_vec(vecs[5]);
    do_reset;
    expect_grant(2'b01, 2'b00, 1'b0, 23'h1000, 256);
    rd_wusedw = {16'd0, 16'd256};
    finish_burst(1'b0);
    expect_grant(2'b00, 2'b01, 1'b1, 23'h3000, 256);
    finish_burst(1'b0);

    // WR_LOAD[0] during WAIT_DONE of the second burst: burst completes, address reloads.
    tag = "midload";
    rd_length = '0;
    wr_length = {9'd0, 9'd256};
    wr_rusedw = {16'd0, 16'd300};
    do_reset;
    expect_grant(2'b00, 2'b01, 1'b1, 23'h3000, 256); finish_burst(1'b0);
    expect_grant(2'b00, 2'b01, 1'b1, 23'h3100, 256); finish_burst(1'b1);
    expect_grant(2'b00, 2'b01, 1'b1, 23'h3000, 256); finish_burst(1'b0);

    // Reset while ISSUE holds rd1's request; a late DONE must not wake the FSM.
    tag = "rstissue";
    apply_vec(vecs[0]);
    do_reset;
    expect_grant(2'b01, 2'b00, 1'b0, 23'h1000, 256); finish_burst(1'b0);
    expect_grant(2'b10, 2'b00, 1'b0, 23'h2000, 256);
    reset = 1'b1;
    tick;
    chk("req", 32'(req), 0);
    chk("masks", 32'({rd_mask, wr_mask}), 0);
    chk("busy", 32'(busy), 0);
    chk("req_addr", 32'(req_addr), 0);
    rd_length = '0;
    reset = 1'b0;
    req_done = 1'b1;
    tick;
    req_done = 1'b0;
    tick;
    chk("late_busy", 32'(busy), 0);
    chk("late_masks", 32'({rd_mask, wr_mask}), 0);
    chk("late_req", 32'(req), 0);
    rd_length = {9'd256, 9'd256};
    expect_grant(2'b01, 2'b00, 1'b0, 23'h1000, 256);
    finish_burst(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
